// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle control unit:
// FSM states, opcodes, funct codes and datapath select values.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_WB_MEM   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_HALT     = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_OUT = 2'b01;

endpackage

// File: rtl/alu_dec.sv
// R-type funct decoder: ALU operation plus a legality flag
// so DECODE can trap unsupported funct codes.
module alu_dec
    import cpu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       valid
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        valid    = 1'b0;
        unique case (funct)
            F_ADD: begin
                alu_ctrl = ALU_ADD;
                valid    = 1'b1;
            end
            F_SUB: begin
                alu_ctrl = ALU_SUB;
                valid    = 1'b1;
            end
            F_SLT: begin
                alu_ctrl = ALU_SLT;
                valid    = 1'b1;
            end
            default: begin
                alu_ctrl = ALU_ADD;
                valid    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/
// write-back and counts retired instructions.
module mc_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             START,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUCtrl,
    output logic [1:0]       PCSource,
    output logic             Halted,
    output logic [CNT_W-1:0] RetireCnt,
    output logic [3:0]       State
);

    state_t           state;
    state_t           state_n;
    logic             is_sw;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f_ctrl;
    logic             f_valid;
    logic             retire;

    alu_dec u_alu_dec (
        .funct    (Funct),
        .alu_ctrl (f_ctrl),
        .valid    (f_valid)
    );

    assign retire = (state == S_WB_R) || (state == S_WB_MEM) ||
                    (state == S_MEM_WR) || (state == S_BRANCH);

    // lw/sw choice is latched in DECODE so MEM_ADDR never looks at Opcode
    always_ff @(posedge CLK) begin
        if (!START) begin
            state <= S_FETCH;
            cnt   <= '0;
            is_sw <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_DECODE)
                is_sw <= (Opcode == OP_SW);
            if (retire && !(&cnt))
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_n  = state;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_REG;
        ALUCtrl  = ALU_ADD;
        PCSource = PCS_ALU;
        Halted   = 1'b0;
        unique case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = SRCB_FOUR;
                state_n = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_BR;
                unique case (1'b1)
                    (Opcode == OP_RTYPE) && f_valid:
                        state_n = S_EXEC_R;
                    (Opcode == OP_LW) || (Opcode == OP_SW):
                        state_n = S_MEM_ADDR;
                    (Opcode == OP_BEQ):
                        state_n = S_BRANCH;
                    default:
                        state_n = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUCtrl = f_ctrl;
                state_n = S_WB_R;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_n  = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_n = is_sw ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_n = S_WB_MEM;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_n  = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_n  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUCtrl  = ALU_SUB;
                PCSource = PCS_OUT;
                PCWrite  = Zero;
                state_n  = S_FETCH;
            end
            S_HALT: begin
                Halted  = 1'b1;
                state_n = S_HALT;
            end
            default: state_n = S_HALT;
        endcase
        // in reset: no enables, selects parked at their FETCH values
        if (!START) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IorD     = 1'b0;
            RegDst   = 1'b0;
            MemtoReg = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = SRCB_FOUR;
            ALUCtrl  = ALU_ADD;
            PCSource = PCS_ALU;
            Halted   = 1'b0;
        end
    end

    assign State     = state;
    assign RetireCnt = cnt;

endmodule
